// File: rtl/mm_bus_pkg.sv
// Shared types and helpers for the memory-mapped peripheral bus arbiter.
package mm_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam logic [15:0] MM_IDLE_DATA = 16'hBEEF;

  // Addresses 0x0000-0x1FFF belong to SRAM; only 0x2000-0xFFFF reach the peripheral port.
  function automatic logic mm_space(input logic [15:0] addr);
    return |addr[15:13];
  endfunction

endpackage

// File: rtl/mm_bus_arbiter_rr_pick.sv
// Combinational round-robin winner select: first set request at or above ptr, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx
);

  logic found;
  int   sel;

  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    sel    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[sel]) begin
        found       = 1'b1;
        onehot[sel] = 1'b1;
        idx         = IDX_W'(sel);
      end
    end
  end

endmodule

// File: rtl/mm_bus_arbiter.sv
// Round-robin arbiter sharing the peripheral slave port between NUM_REQ masters.
// Optional slave wait timeout is enabled by defining MM_TIMEOUT_EN.
module mm_bus_arbiter
  import mm_bus_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      slv_sel,
  output logic                      slv_we,
  output logic [ADDR_W-1:0]         slv_addr,
  output logic [DATA_W-1:0]         slv_wdata,
  input  logic                      slv_rdy,
  input  logic [DATA_W-1:0]         slv_rdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [DATA_W-1:0] IDLE_DATA = DATA_W'(MM_IDLE_DATA);

  if (NUM_REQ < 2 || NUM_REQ > 4 || ADDR_W < 16 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("mm_bus_arbiter: unsupported parameter set");
  end

  state_t              state;
  logic [IDX_W-1:0]    rr_ptr;
  logic [IDX_W-1:0]    win_idx;
  logic [NUM_REQ-1:0]  win_oh;
  logic [NUM_REQ-1:0]  owner;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_wdata;
  logic                win_we;
  logic [IDX_W-1:0]    next_ptr;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req    (req),
    .ptr    (rr_ptr),
    .onehot (win_oh),
    .idx    (win_idx)
  );

  assign win_addr  = req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
  assign win_wdata = req_wdata[int'(win_idx)*DATA_W +: DATA_W];
  assign win_we    = req_we[win_idx];
  assign next_ptr  = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;

`ifdef MM_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
  logic [WAIT_W-1:0] wait_cnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      rdata_q   <= IDLE_DATA;
      err_q     <= 1'b0;
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_rdata <= IDLE_DATA;
      rsp_err   <= 1'b0;
      slv_sel   <= 1'b0;
      slv_we    <= 1'b0;
      slv_addr  <= '0;
      slv_wdata <= '0;
`ifdef MM_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments only, so every register sees pre-edge values.
      gnt       <= '0;
      rsp_valid <= '0;
      unique case (state)
        IDLE: begin
          if (|req) begin
            gnt    <= win_oh;
            owner  <= win_oh;
            rr_ptr <= next_ptr;
            if (mm_space(win_addr[15:0])) begin
              state     <= ACCESS;
              slv_sel   <= 1'b1;
              slv_we    <= win_we;
              slv_addr  <= win_addr;
              slv_wdata <= win_wdata;
`ifdef MM_TIMEOUT_EN
              wait_cnt  <= '0;
`endif
            end else begin
              state   <= RESP;
              err_q   <= 1'b1;
              rdata_q <= IDLE_DATA;
            end
          end
        end
        ACCESS: begin
          // A ready in the final wait cycle still completes the access normally.
          if (slv_rdy) begin
            slv_sel <= 1'b0;
            state   <= RESP;
            err_q   <= 1'b0;
            rdata_q <= slv_we ? IDLE_DATA : slv_rdata;
          end
`ifdef MM_TIMEOUT_EN
          else if (wait_cnt == WAIT_W'(TIMEOUT_CYC - 1)) begin
            slv_sel <= 1'b0;
            state   <= RESP;
            err_q   <= 1'b1;
            rdata_q <= IDLE_DATA;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          rsp_valid <= owner;
          rsp_rdata <= rdata_q;
          rsp_err   <= err_q;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
